// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS-subset control FSM driving aluc, datapath selects and strobes
module mc_control_fsm #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic [3:0] aluc,
  output logic [1:0] alua_sel,
  output logic [1:0] alub_sel,
  output logic       ext_zero,
  output logic       pc_wr,
  output logic [1:0] pc_src,
  output logic       ir_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       m2reg,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_LUI = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b1101;
  localparam logic [3:0] ALU_HAM = 4'b1111;

  state_t cur, nxt;

  logic       d_legal, d_r, d_shift, d_iar, d_zext, d_lui;
  logic       d_lw, d_sw, d_beq, d_bne, d_j;
  logic [3:0] d_aluc;
  logic       pc_wr_d, ir_wr_d, mem_rd_d, mem_wr_d, reg_wr_d, illegal_d;

  assign state = cur;

  always_comb begin
    d_legal = 1'b0;
    d_r     = 1'b0;
    d_shift = 1'b0;
    d_iar   = 1'b0;
    d_zext  = 1'b0;
    d_lui   = 1'b0;
    d_lw    = 1'b0;
    d_sw    = 1'b0;
    d_beq   = 1'b0;
    d_bne   = 1'b0;
    d_j     = 1'b0;
    d_aluc  = ALU_ADD;
    case (op)
      6'b000000: begin
        d_r     = 1'b1;
        d_legal = 1'b1;
        case (func)
          6'b100000: d_aluc = ALU_ADD;
          6'b100010: d_aluc = ALU_SUB;
          6'b100100: d_aluc = ALU_AND;
          6'b100101: d_aluc = ALU_OR;
          6'b100110: d_aluc = ALU_XOR;
          6'b111000: d_aluc = ALU_HAM;
          6'b000000: begin d_aluc = ALU_SLL; d_shift = 1'b1; end
          6'b000010: begin d_aluc = ALU_SRL; d_shift = 1'b1; end
          6'b000011: begin d_aluc = ALU_SRA; d_shift = 1'b1; end
          default:   d_legal = 1'b0;
        endcase
      end
      6'b001000: begin d_legal = 1'b1; d_iar = 1'b1; d_aluc = ALU_ADD; end
      6'b001100: begin d_legal = 1'b1; d_iar = 1'b1; d_zext = 1'b1; d_aluc = ALU_AND; end
      6'b001101: begin d_legal = 1'b1; d_iar = 1'b1; d_zext = 1'b1; d_aluc = ALU_OR; end
      6'b001110: begin d_legal = 1'b1; d_iar = 1'b1; d_zext = 1'b1; d_aluc = ALU_XOR; end
      6'b001111: begin d_legal = 1'b1; d_lui = 1'b1; d_aluc = ALU_LUI; end
      6'b100011: begin d_legal = 1'b1; d_lw = 1'b1; d_aluc = ALU_ADD; end
      6'b101011: begin d_legal = 1'b1; d_sw = 1'b1; d_aluc = ALU_ADD; end
      6'b000100: begin d_legal = 1'b1; d_beq = 1'b1; d_aluc = ALU_SUB; end
      6'b000101: begin d_legal = 1'b1; d_bne = 1'b1; d_aluc = ALU_SUB; end
      6'b000010: begin d_legal = 1'b1; d_j = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    nxt       = S_IF;
    aluc      = ALU_ADD;
    alua_sel  = 2'd0;
    alub_sel  = 2'd0;
    ext_zero  = 1'b0;
    pc_src    = 2'd0;
    iord      = 1'b0;
    reg_dst   = 1'b0;
    m2reg     = 1'b0;
    pc_wr_d   = 1'b0;
    ir_wr_d   = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    reg_wr_d  = 1'b0;
    illegal_d = 1'b0;
    case (cur)
      S_IF: begin
        mem_rd_d = 1'b1;
        alub_sel = 2'd1;
        if (mem_ready) begin
          ir_wr_d = 1'b1;
          pc_wr_d = 1'b1;
          nxt     = S_ID;
        end else begin
          nxt = S_IF;
        end
      end
      S_ID: begin
        // ALUOut captures PC + (sext(imm) << 2) so a branch in EXE can use it
        alub_sel = 2'd3;
        if (!d_legal) begin
          illegal_d = 1'b1;
        end else if (d_j) begin
          pc_wr_d = 1'b1;
          pc_src  = 2'd2;
        end else begin
          nxt = S_EXE;
        end
      end
      S_EXE: begin
        aluc = d_aluc;
        nxt  = S_WB;
        if (d_r) begin
          alua_sel = d_shift ? 2'd2 : 2'd1;
        end else if (d_iar || d_lw || d_sw) begin
          alua_sel = 2'd1;
          alub_sel = 2'd2;
          ext_zero = d_zext;
          if (d_lw || d_sw) nxt = S_MEM;
        end else if (d_lui) begin
          alub_sel = 2'd2;
          ext_zero = 1'b1;
        end else if (d_beq || d_bne) begin
          alua_sel = 2'd1;
          pc_src   = 2'd1;
          pc_wr_d  = d_beq ? z : ~z;
          nxt      = S_IF;
        end else begin
          nxt = S_IF;
        end
      end
      S_MEM: begin
        iord     = 1'b1;
        mem_rd_d = d_lw;
        mem_wr_d = d_sw;
        if (!mem_ready && (d_lw || d_sw)) nxt = S_MEM;
        else if (d_lw)                     nxt = S_WB;
        else                               nxt = S_IF;
      end
      S_WB: begin
        reg_wr_d = 1'b1;
        reg_dst  = d_r;
        m2reg    = d_lw;
      end
      default: nxt = S_IF;
    endcase
  end

  // Strobes are masked by reset in the same cycle so an aborted access never completes
  assign pc_wr   = pc_wr_d   & ~reset;
  assign ir_wr   = ir_wr_d   & ~reset;
  assign mem_rd  = mem_rd_d  & ~reset;
  assign mem_wr  = mem_wr_d  & ~reset;
  assign reg_wr  = reg_wr_d  & ~reset;
  assign illegal = illegal_d & ~reset;

  always_ff @(posedge clock) begin
    if (reset) cur <= state_t'(RESET_STATE);
    else       cur <= nxt;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - table-driven scoreboard bench for mc_control_fsm
module tb_mc_control_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] op, func;
  logic       z, mem_ready;
  logic [2:0] state;
  logic [3:0] aluc;
  logic [1:0] alua_sel, alub_sel, pc_src;
  logic       ext_zero, pc_wr, ir_wr, mem_rd, mem_wr, iord;
  logic       reg_wr, reg_dst, m2reg, illegal;

  mc_control_fsm dut (
    .clock(clock), .reset(reset), .op(op), .func(func), .z(z),
    .mem_ready(mem_ready), .state(state), .aluc(aluc), .alua_sel(alua_sel),
    .alub_sel(alub_sel), .ext_zero(ext_zero), .pc_wr(pc_wr), .pc_src(pc_src),
    .ir_wr(ir_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .m2reg(m2reg), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] aluc;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic       ext;
    logic       pcw;
    logic [1:0] psrc;
    logic       irw;
    logic       mrd;
    logic       mwr;
    logic       iord;
    logic       rw;
    logic       rdst;
    logic       m2r;
    logic       ill;
  } outs_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_J = 6, K_ILL = 7;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] func;
    logic       zz;
    int         kind;
    int         waits;
    logic [3:0] aluc;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic       ext;
  } vec_t;

  outs_t got;
  assign got = {state, aluc, alua_sel, alub_sel, ext_zero, pc_wr, pc_src, ir_wr,
                mem_rd, mem_wr, iord, reg_wr, reg_dst, m2reg, illegal};

  outs_t sb[$];
  string nq[$];
  int    total = 0;
  int    bad = 0;
  outs_t ce;
  string cn;

  always @(negedge clock) begin
    if (sb.size() != 0) begin
      ce = sb.pop_front();
      cn = nq.pop_front();
      total++;
      if (got !== ce) begin
        bad++;
        $display("FAIL %s: got %h want %h", cn, got, ce);
      end
    end
  end

  task automatic expect_cycle(input outs_t e, input string nm);
    sb.push_back(e);
    nq.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  task automatic run(input vec_t v);
    outs_t e;
    op = v.op; func = v.func; z = v.zz; mem_ready = 1'b1;
    e = '0; e.bsel = 2'd1; e.pcw = 1'b1; e.irw = 1'b1; e.mrd = 1'b1;
    expect_cycle(e, {v.name, "/IF"});
    e = '0; e.st = 3'd1; e.bsel = 2'd3;
    if (v.kind == K_J) begin e.pcw = 1'b1; e.psrc = 2'd2; end
    if (v.kind == K_ILL) e.ill = 1'b1;
    expect_cycle(e, {v.name, "/ID"});
    if (v.kind == K_J || v.kind == K_ILL) return;
    e = '0; e.st = 3'd2; e.aluc = v.aluc; e.asel = v.asel; e.bsel = v.bsel; e.ext = v.ext;
    if (v.kind == K_BEQ) begin e.pcw = v.zz;  e.psrc = 2'd1; end
    if (v.kind == K_BNE) begin e.pcw = ~v.zz; e.psrc = 2'd1; end
    expect_cycle(e, {v.name, "/EXE"});
    if (v.kind == K_BEQ || v.kind == K_BNE) return;
    if (v.kind == K_LW || v.kind == K_SW) begin
      for (int i = 0; i <= v.waits; i++) begin
        mem_ready = (i == v.waits);
        e = '0; e.st = 3'd3; e.iord = 1'b1;
        e.mrd = (v.kind == K_LW); e.mwr = (v.kind == K_SW);
        expect_cycle(e, {v.name, "/MEM"});
      end
      mem_ready = 1'b1;
      if (v.kind == K_SW) return;
    end
    e = '0; e.st = 3'd4; e.rw = 1'b1; e.rdst = (v.kind == K_R); e.m2r = (v.kind == K_LW);
    expect_cycle(e, {v.name, "/WB"});
  endtask

  vec_t tbl[18];

  function automatic vec_t mk(input string n, input logic [5:0] o, input logic [5:0] f,
                              input logic zz, input int k, input int w, input logic [3:0] a,
                              input logic [1:0] as, input logic [1:0] bs, input logic ex);
    vec_t v;
    v.name = n; v.op = o; v.func = f; v.zz = zz; v.kind = k; v.waits = w;
    v.aluc = a; v.asel = as; v.bsel = bs; v.ext = ex;
    return v;
  endfunction

  initial begin
    outs_t e;
    tbl[0]  = mk("add",   6'b000000, 6'b100000, 0, K_R,   0, 4'b0000, 2'd1, 2'd0, 0);
    tbl[1]  = mk("sub",   6'b000000, 6'b100010, 0, K_R,   0, 4'b1000, 2'd1, 2'd0, 0);
    tbl[2]  = mk("and",   6'b000000, 6'b100100, 0, K_R,   0, 4'b0111, 2'd1, 2'd0, 0);
    tbl[3]  = mk("ham",   6'b000000, 6'b111000, 0, K_R,   0, 4'b1111, 2'd1, 2'd0, 0);
    tbl[4]  = mk("sra",   6'b000000, 6'b000011, 0, K_R,   0, 4'b1101, 2'd2, 2'd0, 0);
    tbl[5]  = mk("sll",   6'b000000, 6'b000000, 0, K_R,   0, 4'b0001, 2'd2, 2'd0, 0);
    tbl[6]  = mk("ori",   6'b001101, 6'b010101, 0, K_I,   0, 4'b0110, 2'd1, 2'd2, 1);
    tbl[7]  = mk("addi",  6'b001000, 6'b000000, 0, K_I,   0, 4'b0000, 2'd1, 2'd2, 0);
    tbl[8]  = mk("xori",  6'b001110, 6'b000000, 0, K_I,   0, 4'b0100, 2'd1, 2'd2, 1);
    tbl[9]  = mk("lui",   6'b001111, 6'b000000, 0, K_I,   0, 4'b0010, 2'd0, 2'd2, 1);
    tbl[10] = mk("lw",    6'b100011, 6'b000000, 0, K_LW,  3, 4'b0000, 2'd1, 2'd2, 0);
    tbl[11] = mk("sw",    6'b101011, 6'b000000, 0, K_SW,  0, 4'b0000, 2'd1, 2'd2, 0);
    tbl[12] = mk("beq_z1",6'b000100, 6'b000000, 1, K_BEQ, 0, 4'b1000, 2'd1, 2'd0, 0);
    tbl[13] = mk("beq_z0",6'b000100, 6'b000000, 0, K_BEQ, 0, 4'b1000, 2'd1, 2'd0, 0);
    tbl[14] = mk("bne_z1",6'b000101, 6'b000000, 1, K_BNE, 0, 4'b1000, 2'd1, 2'd0, 0);
    tbl[15] = mk("bne_z0",6'b000101, 6'b000000, 0, K_BNE, 0, 4'b1000, 2'd1, 2'd0, 0);
    tbl[16] = mk("j",     6'b000010, 6'b000000, 0, K_J,   0, 4'b0000, 2'd0, 2'd0, 0);
    tbl[17] = mk("ill_op",6'b111111, 6'b000000, 0, K_ILL, 0, 4'b0000, 2'd0, 2'd0, 0);

    reset = 1'b1; op = 6'b000000; func = 6'b100000; z = 1'b0; mem_ready = 1'b1;
    @(posedge clock); #1;
    e = '0; e.bsel = 2'd1;
    expect_cycle(e, "reset_hold");
    reset = 1'b0;

    for (int i = 0; i < 18; i++) run(tbl[i]);
    run(mk("ill_func", 6'b000000, 6'b000001, 0, K_ILL, 0, 4'b0000, 2'd0, 2'd0, 0));

    // sw aborted by reset in the middle of its memory wait
    op = 6'b101011; func = 6'b000000; z = 1'b0; mem_ready = 1'b1;
    e = '0; e.bsel = 2'd1; e.pcw = 1; e.irw = 1; e.mrd = 1;
    expect_cycle(e, "rst_sw/IF");
    e = '0; e.st = 3'd1; e.bsel = 2'd3;
    expect_cycle(e, "rst_sw/ID");
    e = '0; e.st = 3'd2; e.asel = 2'd1; e.bsel = 2'd2;
    expect_cycle(e, "rst_sw/EXE");
    mem_ready = 1'b0;
    e = '0; e.st = 3'd3; e.iord = 1; e.mwr = 1;
    expect_cycle(e, "rst_sw/MEMwait");
    reset = 1'b1;
    e = '0; e.st = 3'd3; e.iord = 1;
    expect_cycle(e, "rst_sw/MEMreset");
    reset = 1'b0;
    e = '0; e.bsel = 2'd1; e.mrd = 1;
    expect_cycle(e, "rst_sw/IFwait");
    mem_ready = 1'b1;
    e = '0; e.bsel = 2'd1; e.pcw = 1; e.irw = 1; e.mrd = 1;
    expect_cycle(e, "rst_sw/IFready");
    e = '0; e.st = 3'd1; e.bsel = 2'd3;
    expect_cycle(e, "rst_sw/ID2");

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
